// File: rtl/emern_vga_pkg.sv
// emern_vga_pkg
//   Shared timing constants for the 640x480@60 raster generator and the pixel
//   core that consumes its position outputs.
//   Contents:
//     DEF_* timing defaults (active, porch, sync widths) and derived totals
//     DEF_HS_*/DEF_VS_* sync window bounds (start inclusive, end exclusive)
//     ACTIVE_COLS/ACTIVE_ROWS  active-area limits seen by the pixel core
//     vga_out_t                the registered output bundle of the generator
//     vga_reset_out()          value of that bundle while in reset
package emern_vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP; // 800
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP; // 525

  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;      // 656
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;    // 752
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;      // 490
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;    // 492

  localparam int ACTIVE_COLS = 640;
  localparam int ACTIVE_ROWS = 480;

  localparam int CNT_W = 10;
  localparam int COL_W = 10;
  localparam int ROW_W = 9;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             cmp_en;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             frame_start;
    logic             line_start;
  } vga_out_t;

  // Syncs are active-low, so their idle level is 1; everything else idles at 0.
  function automatic vga_out_t vga_reset_out();
    vga_out_t o;
    o             = '0;
    o.hsync       = 1'b1;
    o.vsync       = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/emern_vga_timing_counter.sv
// emern_wrap_counter
//   Modulo-(MAX+1) up counter with synchronous active-high reset.
//   Ports:
//     clk   in   clock
//     rst   in   synchronous reset, clears cnt
//     inc   in   advance by one this cycle
//     cnt   out  current count, 0..MAX
//     wrap  out  high while cnt sits at MAX (the next inc returns it to 0);
//                combinational, so a cascaded counter can qualify its own inc
module emern_wrap_counter #(
  parameter int MAX   = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  assign wrap = (cnt == MAX_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/emern_vga_timing.sv
// emern_vga_timing
//   Raster timing generator: horizontal and vertical wrap-around counters
//   followed by a registered decode stage. Every output is a flop, and the
//   outputs describe the position the counters held on the previous tick.
//   Ports:
//     clk          in   pixel clock (or 2x pixel clock with the divider)
//     rst          in   synchronous reset, active-high, wins over en
//     en           in   advance enable; low freezes counters and outputs
//     hsync        out  horizontal sync, active-low
//     vsync        out  vertical sync, active-low
//     cmp_en       out  decoded position lies inside the active area
//     pixel_col    out  active column, 0 outside the active area
//     pixel_row    out  active row, 0 outside the active area
//     frame_start  out  decoded position is (0,0)
//     line_start   out  decoded horizontal position is 0 (every line)
//   Build option:
//     EMERN_VGA_CLKDIV2_EN  advance only on every second enabled cycle so the
//                           block can run from a 2x pixel clock; outputs then
//                           hold for two clk cycles per position.
module emern_vga_timing
  import emern_vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             cmp_en,
  output logic [COL_W-1:0] pixel_col,
  output logic [ROW_W-1:0] pixel_row,
  output logic             frame_start,
  output logic             line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  vga_out_t         dec;
  vga_out_t         out_q;

`ifdef EMERN_VGA_CLKDIV2_EN
  // div resets to 1 so the very first enabled cycle after reset is a tick.
  logic div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= 1'b1;
    end else if (en) begin
      div <= ~div;
    end
  end

  assign tick = en && div;
`else
  assign tick = en;
`endif

  emern_wrap_counter #(
    .MAX   (H_TOTAL - 1),
    .WIDTH (CNT_W)
  ) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (tick),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  // The line counter moves only on the tick that takes h from its last value back to 0.
  emern_wrap_counter #(
    .MAX   (V_TOTAL - 1),
    .WIDTH (CNT_W)
  ) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (tick && h_wrap),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  // v_wrap is only of interest to a cascaded stage; nothing above the frame exists.
  logic v_wrap_unused;
  assign v_wrap_unused = v_wrap;

  always_comb begin
    dec             = '0;
    dec.hsync       = ~((h_cnt >= HS_START_C) && (h_cnt < HS_END_C));
    dec.vsync       = ~((v_cnt >= VS_START_C) && (v_cnt < VS_END_C));
    dec.cmp_en      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    dec.col         = dec.cmp_en ? h_cnt : '0;
    dec.row         = dec.cmp_en ? v_cnt[ROW_W-1:0] : '0;
    dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
    dec.line_start  = (h_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= vga_reset_out();
    end else if (tick) begin
      out_q <= dec;
    end
  end

  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign cmp_en      = out_q.cmp_en;
  assign pixel_col   = out_q.col;
  assign pixel_row   = out_q.row;
  assign frame_start = out_q.frame_start;
  assign line_start  = out_q.line_start;

endmodule

// File: tb/tb_emern_vga_timing.sv
// tb_emern_vga_timing
//   Two instances: u_dut with the 640x480 defaults, and u_small with a reduced
//   raster (30 x 19) so full-frame, vsync and reset-during-vsync behaviour can
//   be exercised in a few hundred cycles. A behavioural model per instance
//   pushes the expected output word every cycle; it is popped and compared
//   after the clock edge. Directed checks then count pulses and periods.
`timescale 1ns/1ps
module tb_emern_vga_timing;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       cmp_en;
    logic [9:0] col;
    logic [8:0] row;
    logic       fs;
    logic       ls;
  } out_t;

  // default raster
  localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
  localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33;
  // reduced raster: 30 clocks per line, 19 lines, 570 ticks per frame
  localparam int B_HA = 16,  B_HFP = 4,  B_HS = 6,  B_HBP = 4;
  localparam int B_VA = 12,  B_VFP = 2,  B_VS = 2,  B_VBP = 3;
  localparam int B_FRAME = 570;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, en_a = 1'b0;
  logic rst_b = 1'b1, en_b = 1'b0;

  logic       hsync_a, vsync_a, cmp_en_a, fs_a, ls_a;
  logic [9:0] col_a;
  logic [8:0] row_a;
  logic       hsync_b, vsync_b, cmp_en_b, fs_b, ls_b;
  logic [9:0] col_b;
  logic [8:0] row_b;

  emern_vga_timing u_dut (
    .clk         (clk),
    .rst         (rst_a),
    .en          (en_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .cmp_en      (cmp_en_a),
    .pixel_col   (col_a),
    .pixel_row   (row_a),
    .frame_start (fs_a),
    .line_start  (ls_a)
  );

  emern_vga_timing #(
    .H_ACTIVE (B_HA), .H_FP (B_HFP), .H_SYNC (B_HS), .H_BP (B_HBP),
    .V_ACTIVE (B_VA), .V_FP (B_VFP), .V_SYNC (B_VS), .V_BP (B_VBP)
  ) u_small (
    .clk         (clk),
    .rst         (rst_b),
    .en          (en_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .cmp_en      (cmp_en_b),
    .pixel_col   (col_b),
    .pixel_row   (row_b),
    .frame_start (fs_b),
    .line_start  (ls_b)
  );

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q_a[$];
  logic [23:0] exp_q_b[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int   a_h = 0, a_v = 0, b_h = 0, b_v = 0;
  logic a_div = 1'b1, b_div = 1'b1;
  logic a_tk = 1'b0, b_tk = 1'b0;
  out_t a_o, b_o;

  function automatic out_t reset_out();
    out_t o;
    o = '0;
    o.hsync = 1'b1;
    o.vsync = 1'b1;
    return o;
  endfunction

  function automatic out_t decode(input int h, input int v, input int ha, input int hfp,
                                  input int hs, input int va, input int vfp, input int vs);
    out_t o;
    o        = '0;
    o.hsync  = !((h >= ha + hfp) && (h < ha + hfp + hs));
    o.vsync  = !((v >= va + vfp) && (v < va + vfp + vs));
    o.cmp_en = (h < ha) && (v < va);
    o.col    = o.cmp_en ? 10'(h) : 10'd0;
    o.row    = o.cmp_en ? 9'(v) : 9'd0;
    o.fs     = (h == 0) && (v == 0);
    o.ls     = (h == 0);
    return o;
  endfunction

  task automatic model_step(input logic r, input logic e,
                            input int ha, input int hfp, input int hs, input int hbp,
                            input int va, input int vfp, input int vs, input int vbp,
                            inout int h, inout int v, inout logic d, inout out_t o,
                            output logic tk);
    tk = 1'b0;
    if (r) begin
      h = 0;
      v = 0;
      d = 1'b1;
      o = reset_out();
    end else begin
`ifdef EMERN_VGA_CLKDIV2_EN
      tk = e && d;
      if (e) d = ~d;
`else
      tk = e;
`endif
      if (tk) begin
        o = decode(h, v, ha, hfp, hs, va, vfp, vs);
        h++;
        if (h == ha + hfp + hs + hbp) begin
          h = 0;
          v++;
          if (v == va + vfp + vs + vbp) v = 0;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [23:0] e;
    model_step(rst_a, en_a, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP,
               a_h, a_v, a_div, a_o, a_tk);
    exp_q_a.push_back(a_o);
    model_step(rst_b, en_b, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP,
               b_h, b_v, b_div, b_o, b_tk);
    exp_q_b.push_back(b_o);
    @(posedge clk);
    #1;
    if (exp_q_a.size() == 0) check("a.queue", 0, 1);
    else begin
      e = exp_q_a.pop_front();
      check("a.out", {8'd0, hsync_a, vsync_a, cmp_en_a, col_a, row_a, fs_a, ls_a}, {8'd0, e});
    end
    if (exp_q_b.size() == 0) check("b.queue", 0, 1);
    else begin
      e = exp_q_b.pop_front();
      check("b.out", {8'd0, hsync_b, vsync_b, cmp_en_b, col_b, row_b, fs_b, ls_b}, {8'd0, e});
    end
  endtask

  task automatic tick_a();
    int k = 0;
    do begin
      cycle();
      k++;
    end while (!a_tk && k < 4);
    if (!a_tk) check("a.tick_bound", 0, 1);
  endtask

  task automatic tick_b();
    int k = 0;
    do begin
      cycle();
      k++;
    end while (!b_tk && k < 4);
    if (!b_tk) check("b.tick_bound", 0, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int act, hs_low, hs_first, hs_last, found;
    int fs_cnt, fs_second, ls_cnt, vs_low, vs_first, vs_run, vs_run_max, row_max;

    // reset state
    cycle();
    cycle();
    rst_a = 1'b0;
    rst_b = 1'b0;
    cycle();
    check("a.reset_hsync", hsync_a, 1);
    check("a.reset_cmp_en", cmp_en_a, 0);

    // first tick decodes (0,0)
    en_a = 1'b1;
    tick_a();
    check("a.first_fs", fs_a, 1);
    check("a.first_ls", ls_a, 1);
    check("a.first_cmp_en", cmp_en_a, 1);
    check("a.first_col_row", {col_a, row_a}, 0);
    check("a.first_syncs", {hsync_a, vsync_a}, 2'b11);

    // rest of the first line: outputs 2..800
    act = 1; hs_low = 0; hs_first = 0; hs_last = 0;
    for (int i = 2; i <= 800; i++) begin
      tick_a();
      if (cmp_en_a) act++;
      if (!hsync_a) begin
        hs_low++;
        if (hs_first == 0) hs_first = i;
        hs_last = i;
      end
    end
    check("a.active_count", act, 640);
    check("a.hsync_low_count", hs_low, 96);
    check("a.hsync_first", hs_first, 657);
    check("a.hsync_last", hs_last, 752);
    tick_a();  // output 801
    check("a.line2_ls", ls_a, 1);
    check("a.line2_row", row_a, 1);
    check("a.line2_col", col_a, 0);

    // freeze mid-line at col 300
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick_a();
      if (cmp_en_a && col_a == 10'd300) found = 1;
    end
    check("a.reach_col300", found, 1);
    en_a = 1'b0;
    repeat (37) cycle();
    check("a.frozen_col", col_a, 300);
    check("a.frozen_ls", ls_a, 0);
    en_a = 1'b1;
    tick_a();
    check("a.resume_col", col_a, 301);
    en_a = 1'b0;

    // reduced raster: two full frames plus one tick
    en_b = 1'b1;
    fs_cnt = 0; fs_second = 0; ls_cnt = 0; vs_low = 0; vs_first = 0;
    vs_run = 0; vs_run_max = 0; row_max = 0;
    for (int t = 1; t <= 2 * B_FRAME + 1; t++) begin
      tick_b();
      if (fs_b) begin
        fs_cnt++;
        if (fs_cnt == 2) fs_second = t;
      end
      if (ls_b) ls_cnt++;
      if (!vsync_b) begin
        vs_low++;
        vs_run++;
        if (vs_first == 0) vs_first = t;
        if (vs_run > vs_run_max) vs_run_max = vs_run;
      end else begin
        vs_run = 0;
      end
      if (cmp_en_b && int'(row_b) > row_max) row_max = int'(row_b);
    end
    check("b.fs_count", fs_cnt, 3);
    check("b.fs_period", fs_second, B_FRAME + 1);
    check("b.ls_count", ls_cnt, 39);
    check("b.vsync_low_total", vs_low, 2 * B_VS * 30);
    check("b.vsync_run", vs_run_max, B_VS * 30);
    check("b.vsync_first", vs_first, 14 * 30 + 1);
    check("b.row_max", row_max, B_VA - 1);

    // reset while in vsync and hsync (counters at h=22, v=15)
    found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      tick_b();
      if (b_h == 22 && b_v == 15) found = 1;
    end
    check("b.reach_rst_point", found, 1);
    check("b.pre_rst_vsync", vsync_b, 0);
    check("b.pre_rst_hsync", hsync_b, 0);
    rst_b = 1'b1;
    cycle();
    check("b.rst_syncs", {hsync_b, vsync_b}, 2'b11);
    check("b.rst_h_cnt", u_small.h_cnt, 0);
    check("b.rst_v_cnt", u_small.v_cnt, 0);
    check("b.rst_fs", fs_b, 0);
    rst_b = 1'b0;
    tick_b();
    check("b.post_rst_fs", fs_b, 1);
    check("b.post_rst_cmp_en", cmp_en_b, 1);
    en_b = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
